// File: rtl/sdram_arbiter.sv
// Two-port fixed-priority arbiter in front of sdram_controller: port 0 wins by default,
// port 1 is forced through after STARVE_LIMIT consecutive port-0 grants while it waits.
module sdram_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rvalid,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_wr_data,
  output logic              sd_wr_enable,
  output logic              sd_rd_enable,
  input  logic [DATA_W-1:0] sd_rd_data,
  input  logic              sd_rd_ready,
  input  logic              sd_busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCEPT, COMPLETE} state_t;

  // Handshake: a port holds req (with we/addr/wdata stable) until a one-cycle ack;
  // ack coincides with the single-cycle controller enable; rvalid is a one-cycle
  // pulse and rdata holds until that port's next read returns.
  state_t           state, state_next;
  logic [CNT_W-1:0] streak;
  logic             op_we;
  logic             owner;
  logic             grant;
  logic             grant_port;
  logic             finish_read;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    grant_port  = 1'b0;
    finish_read = 1'b0;
    case (state)
      IDLE: begin
        if (!sd_busy && (p0_req || p1_req)) begin
          grant      = 1'b1;
          grant_port = p1_req && (!p0_req || streak == LIMIT);
          state_next = ACCEPT;
        end
      end
      ACCEPT: begin
        // A fast controller may return read data before busy is ever seen.
        if (!op_we && sd_rd_ready) begin
          finish_read = 1'b1;
          state_next  = IDLE;
        end else if (sd_busy) begin
          state_next = COMPLETE;
        end
      end
      COMPLETE: begin
        if (op_we) begin
          if (!sd_busy) state_next = IDLE;
        end else if (sd_rd_ready) begin
          finish_read = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_rvalid    <= 1'b0;
      p1_rvalid    <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      sd_addr      <= '0;
      sd_wr_data   <= '0;
      sd_wr_enable <= 1'b0;
      sd_rd_enable <= 1'b0;
      op_we        <= 1'b0;
      owner        <= 1'b0;
    end else begin
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_rvalid    <= 1'b0;
      p1_rvalid    <= 1'b0;
      sd_wr_enable <= 1'b0;
      sd_rd_enable <= 1'b0;
      if (grant) begin
        owner <= grant_port;
        if (grant_port) begin
          op_we        <= p1_we;
          sd_addr      <= p1_addr;
          sd_wr_data   <= p1_wdata;
          p1_ack       <= 1'b1;
          sd_wr_enable <= p1_we;
          sd_rd_enable <= !p1_we;
        end else begin
          op_we        <= p0_we;
          sd_addr      <= p0_addr;
          sd_wr_data   <= p0_wdata;
          p0_ack       <= 1'b1;
          sd_wr_enable <= p0_we;
          sd_rd_enable <= !p0_we;
        end
      end
      if (finish_read) begin
        if (owner) begin
          p1_rdata  <= sd_rd_data;
          p1_rvalid <= 1'b1;
        end else begin
          p0_rdata  <= sd_rd_data;
          p0_rvalid <= 1'b1;
        end
      end
    end
  end

  // Streak counts port-0 wins that happened while port 1 was waiting.
  always_ff @(posedge clk) begin
    if (reset || !p1_req) begin
      streak <= '0;
    end else if (grant && grant_port) begin
      streak <= '0;
    end else if (grant && streak != LIMIT) begin
      streak <= streak + CNT_W'(1);
    end
  end

endmodule
